// File: rtl/gl_inst_writer.sv
// Producer side of the GL instruction BRAM ring: packs commands into header + operand words.
// Optional GL_INST_WRITER_STATS_EN adds the inst_count accepted-command counter port.
module gl_inst_writer #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          DEPTH     = 256,
    localparam int         AW        = $clog2(DEPTH),
    localparam int         FW        = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_opcode,
    input  logic [22:0]   cmd_imm,
    input  logic          cmd_type,
    input  logic [2:0]    cmd_nargs,
    input  logic          arg_valid,
    output logic          arg_ready,
    input  logic [31:0]   arg_data,
    output logic          wr_en,
    output logic [31:0]   wr_addr,
    output logic [31:0]   wr_data,
    input  logic          retire_en,
    input  logic [2:0]    retire_cnt,
    output logic [FW-1:0] free_words,
    output logic          err
`ifdef GL_INST_WRITER_STATS_EN
    ,
    output logic [31:0]   inst_count
`endif
);

    typedef enum logic {S_IDLE, S_ARGS} state_t;

    state_t          state;
    logic [AW-1:0]   wp;
    logic [2:0]      remaining;
    logic [2:0]      n_eff;
    logic            bad_nargs;
    logic [FW-1:0]   need;
    logic            cmd_fire;
    logic            arg_fire;
    logic [FW-1:0]   reserve;
    logic [FW:0]     credit_sum;
    logic            credit_ovf;
    logic            retire_zero;

    // Out-of-range operand counts are clamped so the ring layout stays consistent.
    assign bad_nargs = (cmd_nargs > 3'd4);
    assign n_eff     = bad_nargs ? 3'd4 : cmd_nargs;
    assign need      = FW'(n_eff) + FW'(1);

    assign cmd_ready = (state == S_IDLE) && (free_words >= need);
    assign arg_ready = (state == S_ARGS);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign arg_fire  = arg_valid && arg_ready;

    // Whole command's credits are reserved at accept time, so operands never stall on space.
    assign reserve     = cmd_fire ? need : '0;
    assign credit_sum  = {1'b0, free_words} - {1'b0, reserve}
                       + (retire_en ? (FW+1)'(retire_cnt) : '0);
    assign credit_ovf  = credit_sum > (FW+1)'(DEPTH);
    assign retire_zero = retire_en && (retire_cnt == 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wp         <= '0;
            remaining  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= '0;
            free_words <= FW'(DEPTH);
            err        <= 1'b0;
        end else begin
            wr_en <= cmd_fire || arg_fire;
            if (cmd_fire) begin
                wr_addr   <= BASE_ADDR + {{(32-AW){1'b0}}, wp};
                wr_data   <= {cmd_type, cmd_imm, cmd_opcode};
                wp        <= wp + AW'(1);
                remaining <= n_eff;
                if (n_eff != 3'd0) state <= S_ARGS;
            end else if (arg_fire) begin
                wr_addr   <= BASE_ADDR + {{(32-AW){1'b0}}, wp};
                wr_data   <= arg_data;
                wp        <= wp + AW'(1);
                remaining <= remaining - 3'd1;
                if (remaining == 3'd1) state <= S_IDLE;
            end
            free_words <= credit_ovf ? FW'(DEPTH) : credit_sum[FW-1:0];
            if ((cmd_fire && bad_nargs) || credit_ovf || retire_zero) err <= 1'b1;
        end
    end

`ifdef GL_INST_WRITER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         inst_count <= '0;
        else if (cmd_fire) inst_count <= inst_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_gl_inst_writer.sv
// Randomized and directed bench for gl_inst_writer against a credit/ring reference model.
// Build with GL_INST_WRITER_STATS_EN defined to also cover inst_count.
module tb_gl_inst_writer;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          FW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_type;
    logic [7:0]    cmd_opcode;
    logic [22:0]   cmd_imm;
    logic [2:0]    cmd_nargs;
    logic          arg_valid, arg_ready;
    logic [31:0]   arg_data;
    logic          wr_en;
    logic [31:0]   wr_addr, wr_data;
    logic          retire_en;
    logic [2:0]    retire_cnt;
    logic [FW-1:0] free_words;
    logic          err;
`ifdef GL_INST_WRITER_STATS_EN
    logic [31:0]   inst_count;
`endif

    gl_inst_writer #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_imm(cmd_imm), .cmd_type(cmd_type), .cmd_nargs(cmd_nargs),
        .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .retire_en(retire_en), .retire_cnt(retire_cnt),
        .free_words(free_words), .err(err)
`ifdef GL_INST_WRITER_STATS_EN
        , .inst_count(inst_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: credits, ring position, operands still owed, sticky error.
    int          m_free, m_wp, m_rem, m_cnt;
    bit          m_err, acc;
    bit          e_wen;
    logic [31:0] e_addr, e_data;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_opcode = 0; cmd_imm = 0; cmd_type = 0; cmd_nargs = 0;
        arg_valid = 0; arg_data = 0; retire_en = 0; retire_cnt = 0;
    endtask

    task automatic model_init();
        m_free = DEPTH; m_wp = 0; m_rem = 0; m_cnt = 0; m_err = 0;
        e_wen = 0; e_addr = BASE; e_data = 0;
    endtask

    task automatic check_reset_state();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_free", 32'(free_words), 32'(DEPTH));
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_arg_ready", 32'(arg_ready), 32'd0);
`ifdef GL_INST_WRITER_STATS_EN
        chk("rst_inst_count", inst_count, 32'd0);
`endif
    endtask

    task automatic rst_release();
        @(negedge clk);
        reset = 0;
        model_init();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_release();
    endtask

    // One clock: readies checked mid-cycle, model advanced at the edge, registers checked after.
    task automatic step();
        int eff, res;
        @(negedge clk);
        eff = (cmd_nargs > 4) ? 4 : int'(cmd_nargs);
        chk("cmd_ready", 32'(cmd_ready), 32'(m_rem == 0 && m_free >= eff + 1));
        chk("arg_ready", 32'(arg_ready), 32'(m_rem > 0));
        @(posedge clk);
        acc   = cmd_valid && m_rem == 0 && m_free >= eff + 1;
        res   = 0;
        e_wen = 0;
        if (acc) begin
            e_wen  = 1;
            e_addr = BASE + 32'(m_wp);
            e_data = {cmd_type, cmd_imm, cmd_opcode};
            m_wp   = (m_wp + 1) % DEPTH;
            res    = eff + 1;
            m_rem  = eff;
            m_cnt++;
            if (cmd_nargs > 4) m_err = 1;
        end else if (arg_valid && m_rem > 0) begin
            e_wen  = 1;
            e_addr = BASE + 32'(m_wp);
            e_data = arg_data;
            m_wp   = (m_wp + 1) % DEPTH;
            m_rem--;
        end
        if (retire_en && retire_cnt == 0) m_err = 1;
        m_free = m_free - res + (retire_en ? int'(retire_cnt) : 0);
        if (m_free > DEPTH) begin
            m_free = DEPTH;
            m_err  = 1;
        end
        #1;
        chk("wr_en", 32'(wr_en), 32'(e_wen));
        if (e_wen) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
        end
        chk("free_words", 32'(free_words), 32'(m_free));
        chk("err", 32'(err), 32'(m_err));
`ifdef GL_INST_WRITER_STATS_EN
        chk("inst_count", inst_count, 32'(m_cnt));
`endif
    endtask

    task automatic send_cmd(input logic [2:0] na);
        int eff;
        eff        = (na > 4) ? 4 : int'(na);
        retire_en  = 0;
        cmd_valid  = 1;
        cmd_nargs  = na;
        cmd_opcode = 8'($urandom);
        cmd_imm    = 23'($urandom);
        cmd_type   = 1'($urandom);
        for (int t = 0; t < 20; t++) begin
            step();
            if (acc) break;
        end
        cmd_valid = 0;
        if (!acc) chk("cmd_accept_timeout", 32'd0, 32'd1);
        arg_valid = 1;
        for (int a = 0; a < eff; a++) begin
            arg_data = $urandom;
            step();
        end
        arg_valid = 0;
    endtask

    initial begin
        int accepted;
        int out, cnt;

        reset = 1;
        idle_inputs();
        model_init();
        do_reset();

        // Worked example: header plus two operands at addresses 0..2.
        cmd_valid = 1; cmd_opcode = 8'h12; cmd_imm = 23'h000ABC; cmd_type = 1; cmd_nargs = 3'd2;
        step();
        chk("ex_hdr_addr", wr_addr, 32'd0);
        chk("ex_hdr_data", wr_data, 32'h800ABC12);
        cmd_valid = 0; arg_valid = 1; arg_data = 32'hDEADBEEF;
        step();
        chk("ex_arg0_addr", wr_addr, 32'd1);
        chk("ex_arg0_data", wr_data, 32'hDEADBEEF);
        arg_data = 32'h01234567;
        step();
        chk("ex_arg1_addr", wr_addr, 32'd2);
        chk("ex_arg1_data", wr_data, 32'h01234567);
        chk("ex_free", 32'(free_words), 32'd253);
        arg_valid = 0;
        step();
        chk("ex_pulse", 32'(wr_en), 32'd0);

        // Fill the ring with four-operand commands until credits run out.
        do_reset();
        accepted = 0;
        for (int i = 0; i < 63; i++) begin
            cmd_valid = 1; cmd_nargs = 3'd4; cmd_opcode = 8'($urandom);
            step();
            if (!acc) break;
            accepted++;
            cmd_valid = 0; arg_valid = 1;
            for (int a = 0; a < 4; a++) begin
                arg_data = $urandom;
                step();
            end
            arg_valid = 0;
        end
        chk("fill_accepted", 32'(accepted), 32'd51);
        chk("fill_free", 32'(free_words), 32'd1);
        chk("fill_blocked", 32'(cmd_ready), 32'd0);
        cmd_valid = 0; retire_en = 1; retire_cnt = 3'd5;
        step();
        chk("fill_retire_free", 32'(free_words), 32'd6);
        retire_en = 0; cmd_valid = 1; cmd_nargs = 3'd4;
        step();
        chk("fill_resume", 32'(acc), 32'd1);
        cmd_valid = 0; arg_valid = 1;
        repeat (4) step();
        arg_valid = 0;

        // Command straddling the ring wrap.
        do_reset();
        cmd_valid = 1; cmd_nargs = 3'd0; retire_en = 1; retire_cnt = 3'd1;
        repeat (254) step();
        cmd_valid = 1; cmd_nargs = 3'd3; retire_en = 0;
        step();
        chk("wrap_hdr_addr", wr_addr, 32'd254);
        cmd_valid = 0; arg_valid = 1;
        step(); chk("wrap_a0_addr", wr_addr, 32'd255);
        step(); chk("wrap_a1_addr", wr_addr, 32'd0);
        step(); chk("wrap_a2_addr", wr_addr, 32'd1);
        arg_valid = 0;

        // Same-cycle reserve and retire, then overflow saturation.
        do_reset();
        repeat (49) send_cmd(3'd4);
        send_cmd(3'd0);
        chk("sc_free10", 32'(free_words), 32'd10);
        cmd_valid = 1; cmd_nargs = 3'd0; retire_en = 1; retire_cnt = 3'd3;
        step();
        chk("sc_free12", 32'(free_words), 32'd12);
        cmd_valid = 0; retire_cnt = 3'd5;
        repeat (48) step();
        retire_cnt = 3'd2;
        step();
        chk("sc_free254", 32'(free_words), 32'd254);
        chk("sc_err_clear", 32'(err), 32'd0);
        retire_cnt = 3'd5;
        step();
        chk("ovf_free", 32'(free_words), 32'(DEPTH));
        chk("ovf_err", 32'(err), 32'd1);
        retire_en = 0;
        repeat (2) step();
        chk("ovf_err_sticky", 32'(err), 32'd1);

        // Out-of-range nargs is an error and behaves like four operands.
        do_reset();
        send_cmd(3'd6);
        chk("nargs6_err", 32'(err), 32'd1);
        chk("nargs6_free", 32'(free_words), 32'd251);
        chk("nargs6_idle", 32'(cmd_ready), 32'd1);

        // Zero-count retire is an error.
        do_reset();
        retire_en = 1; retire_cnt = 3'd0;
        step();
        chk("retire0_err", 32'(err), 32'd1);
        retire_en = 0;

        // Asynchronous reset in the middle of a command's operands.
        do_reset();
        cmd_valid = 1; cmd_nargs = 3'd4;
        step();
        cmd_valid = 0; arg_valid = 1; arg_data = 32'hA5A5_0001;
        step();
        chk("mid_wr_en_before", 32'(wr_en), 32'd1);
        #2 reset = 1;
        #1;
        chk("mid_wr_en", 32'(wr_en), 32'd0);
        chk("mid_free", 32'(free_words), 32'(DEPTH));
        chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_arg_ready", 32'(arg_ready), 32'd0);
        idle_inputs();
        rst_release();

`ifdef GL_INST_WRITER_STATS_EN
        repeat (3) send_cmd(3'd0);
        chk("stats_three", inst_count, 32'd3);
        reset = 1;
        #1;
        chk("stats_cleared", inst_count, 32'd0);
        rst_release();
`endif

        // Randomized traffic with legal retires driven from the model's outstanding words.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cmd_valid  = (m_rem == 0) && ($urandom_range(0, 1) == 1);
            cmd_nargs  = 3'($urandom_range(0, 4));
            cmd_opcode = 8'($urandom);
            cmd_imm    = 23'($urandom);
            cmd_type   = 1'($urandom);
            arg_valid  = ($urandom_range(0, 9) < 7);
            arg_data   = $urandom;
            out        = DEPTH - m_free;
            retire_en  = 0;
            retire_cnt = 0;
            if (out > 0 && $urandom_range(0, 3) == 0) begin
                cnt        = $urandom_range(1, (out < 5) ? out : 5);
                retire_en  = 1;
                retire_cnt = 3'(cnt);
            end
            step();
        end
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gl_inst_writer.md
# gl_inst_writer

Producer end of the instruction BRAM ring that `gl_fetch` reads and `gl_decode` reads operands from. Accepts GL commands (opcode, immediate, type, 0–4 operand words) from the host-side command source. Packs each command into one header word followed by its operand words, and writes them into consecutive BRAM word addresses with wrap-around. Tracks free space with a credit counter, replenished by retire pulses from the decode side, so unread words are never overwritten.

## Interface
Parameters:
- `BASE_ADDR`, default 0: word address of ring slot 0.
- `DEPTH`, default 256: ring size in words; power of two, ≥ 8.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on `cmd_valid & cmd_ready`.
- `cmd_opcode` in 8: instruction opcode.
- `cmd_imm` in 23: immediate field.
- `cmd_type` in 1: instruction type bit.
- `cmd_nargs` in 3: number of operand words to follow, 0–4.
- `arg_valid` in 1: operand word present.
- `arg_ready` out 1: operand accepted on `arg_valid & arg_ready`.
- `arg_data` in 32: operand word.
- `wr_en` out 1: BRAM write strobe (registered).
- `wr_addr` out 32: BRAM word address (registered).
- `wr_data` out 32: BRAM write data (registered).
- `retire_en` in 1: decode has finished with `retire_cnt` words.
- `retire_cnt` in 3: words freed, 1–5.
- `free_words` out `$clog2(DEPTH)+1`: current credit count.
- `err` out 1: sticky error flag.
- `inst_count` out 32: present only with `GL_INST_WRITER_STATS_EN`.

## Operation
- Header word format: `{cmd_type, cmd_imm[22:0], cmd_opcode[7:0]}`, i.e. bit 31 = type, bits 30:8 = imm, bits 7:0 = opcode.
- `cmd_nargs` values 5–7 set `err` and are treated as 4.
- States:
  - IDLE: `cmd_ready = (free_words >= n+1)`, where n is the effective nargs. `cmd_ready` is combinational on the registered `free_words` and the current `cmd_nargs`.
  - On accept: register the header write, reserve n+1 credits (`free_words -= n+1`) and latch n. If n = 0, remain in IDLE; otherwise go to ARGS with remaining = n.
  - ARGS: `cmd_ready = 0`; `arg_ready = 1`. Each arg handshake registers a write of `arg_data` and decrements remaining. After the last operand, return to IDLE.
  - `arg_ready = 0` in IDLE; stray `arg_valid` is ignored.
- Write pointer `wp` is `$clog2(DEPTH)` bits. Each write uses `wr_addr = BASE_ADDR + wp`, then `wp` increments and wraps DEPTH-1 → 0. Commands may straddle the wrap.
- Credits: `free_words_next = free_words - reserve + (retire_en ? retire_cnt : 0)`. Reservation and retire in the same cycle are both applied.
- If the sum exceeds DEPTH, it saturates at DEPTH and sets `err`. `retire_cnt = 0` with `retire_en` sets `err`.
- `err` clears only on reset.

## Timing
- Reset values: `wr_en` 0, `wr_addr` BASE_ADDR, `wr_data` 0, `free_words` DEPTH, `err` 0, `inst_count` 0, state IDLE, `wp` 0.
- `cmd_ready` is 1 immediately after reset; `arg_ready` is 0.
- Latency: handshake on edge k → `wr_en` = 1 with the corresponding data during cycle k+1.
- `wr_en` is a one-cycle pulse per word.
- Throughput:
  - One zero-operand command per cycle.
  - An n-operand command takes 1+n cycles when operands are continuously valid.
  - Arg bubbles stall without limit.
- Retire takes effect on `free_words` one edge later; `cmd_ready` reflects it in the following cycle.
- Reset mid-command (in ARGS) discards the partial command. The words already written remain in BRAM, but credits are restored to DEPTH.

## Configuration
- `GL_INST_WRITER_STATS_EN` defined: `inst_count` port exists; it increments by 1 on each accepted command and wraps at 2^32.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset → `cmd_ready` = 1, `free_words` = 256, `wr_addr` = BASE_ADDR, `wr_en` = 0.
- Command opcode 0x12, imm 0x000ABC, type 1, nargs 2; args 0xDEADBEEF, 0x01234567 → writes at addresses 0, 1, 2 with data 0x800ABC12, 0xDEADBEEF, 0x01234567, each one cycle after its handshake; `free_words` = 253.
- Fill with 63 four-arg commands (315 words attempted, DEPTH 256) and no retires → `cmd_ready` drops once `free_words` < 5 (at `free_words` = 1 after 51 commands). Then `retire_en`/`retire_cnt` = 5 → `free_words` = 6 and `cmd_ready` rises the next cycle.
- Write pointer at 254, command with nargs 3 → addresses 254, 255, 0, 1.
- Same-cycle accept (nargs 0) and retire 3 from `free_words` 10 → 12. Retire 5 at `free_words` 254 → 256 and `err` = 1.
- Reset asserted mid-ARGS after 1 of 4 operands → state IDLE, `free_words` = DEPTH, `wr_en` = 0 asynchronously. With `GL_INST_WRITER_STATS_EN`, 3 commands then reset → `inst_count` goes 3 → 0.
